onfi_cmd_sequencer: RTL

Sequences one ONFI operation at a time onto the shared command/address pins: chip-enable setup, first command cycle, 0–5 address cycles, optional second command cycle, tWB gap, then wait for R/B# ready. It sits between the controller's operation front-end (reset, read-status, page-read, erase issuers) and the ONFI pad signals. It generalizes the fixed FFh reset sequence into a request-driven engine, so every command type shares one driver for CE/CLE/ALE/DQ.

---
 rtl/onfi_cmd_sequencer.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/onfi_cmd_sequencer.sv
// onfi_cmd_sequencer: one ONFI command/address operation at a time onto the
// shared CE#/CLE/ALE/DQ pins, then waits for R/B# ready.
// All state updates on the falling edge of onfi_clk; synchronous active-low reset.
// Optional feature: define ONFI_RB_TIMEOUT_EN to bound the R/B# busy wait
// with TIMEOUT_CYCLES and report expiry on op_err.
module onfi_cmd_sequencer #(
  parameter int unsigned MAX_ADDR       = 5,
  parameter int unsigned TWB_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        onfi_clk,
  input  logic        onfi_rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd1,
  input  logic [2:0]  req_naddr,
  input  logic [39:0] req_addr,
  input  logic        req_has_cmd2,
  input  logic [7:0]  req_cmd2,
  input  logic        onfi_rb,
  output logic        op_done,
  output logic        op_err,
  output logic        busy,
  output logic        onfi_cen,
  output logic        onfi_cle,
  output logic        onfi_ale,
  output logic        onfi_wen,
  output logic        onfi_dqs_en,
  output logic [31:0] onfi_dq_o,
  output logic        onfi_dq_en
);

  localparam int unsigned CMD_W   = 8;
  localparam int unsigned NADDR_W = 3;
  localparam int unsigned ADDR_W  = 40;
  localparam int unsigned DQ_W    = 32;
  localparam int unsigned TWB_W   = 8;

  localparam logic [NADDR_W-1:0] MAX_ADDR_C = NADDR_W'(MAX_ADDR);
  localparam logic [TWB_W-1:0]   TWB_LAST   = TWB_W'(TWB_CYCLES - 1);

`ifdef ONFI_RB_TIMEOUT_EN
  localparam int unsigned      TO_W    = 16;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD1,
    S_ADDR,
    S_CMD2,
    S_GAP,
    S_BUSY,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CMD_W-1:0]     cmd1_q, cmd1_d;
  logic [CMD_W-1:0]     cmd2_q, cmd2_d;
  logic                 has_cmd2_q, has_cmd2_d;
  logic [NADDR_W-1:0]   naddr_q, naddr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [NADDR_W-1:0]   idx_q, idx_d;
  logic [TWB_W-1:0]     twb_q, twb_d;
  logic                 timeout_hit;

  // Registered pin/handshake outputs, computed from the next state
  logic                 cen_q, cen_d;
  logic                 cle_q, cle_d;
  logic                 ale_q, ale_d;
  logic                 dq_en_q, dq_en_d;
  logic [CMD_W-1:0]     dq_q, dq_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic [CMD_W-1:0]     addr_byte;

  logic                 rb_meta_q, rb_s_q;

`ifdef ONFI_RB_TIMEOUT_EN
  logic [TO_W-1:0]      to_q, to_d;
  logic                 err_q, err_d;
`else
  logic                 unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES};
`endif

  // Two-flop synchronizer for the asynchronous R/B# pin
  always_ff @(negedge onfi_clk) begin
    if (!onfi_rstn) begin
      rb_meta_q <= 1'b0;
      rb_s_q    <= 1'b0;
    end else begin
      rb_meta_q <= onfi_rb;
      rb_s_q    <= rb_meta_q;
    end
  end

  // Address byte selected by the next address index
  always_comb begin
    addr_byte = '0;
    case (idx_d)
      3'd0:    addr_byte = addr_q[7:0];
      3'd1:    addr_byte = addr_q[15:8];
      3'd2:    addr_byte = addr_q[23:16];
      3'd3:    addr_byte = addr_q[31:24];
      3'd4:    addr_byte = addr_q[39:32];
      default: addr_byte = '0;
    endcase
  end

  // Next-state, request capture, counters and next output values
  always_comb begin
    state_d     = state_q;
    cmd1_d      = cmd1_q;
    cmd2_d      = cmd2_q;
    has_cmd2_d  = has_cmd2_q;
    naddr_d     = naddr_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    twb_d       = twb_q;
    timeout_hit = 1'b0;
`ifdef ONFI_RB_TIMEOUT_EN
    to_d        = to_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          cmd1_d     = req_cmd1;
          cmd2_d     = req_cmd2;
          has_cmd2_d = req_has_cmd2;
          addr_d     = req_addr;
          naddr_d    = (req_naddr > MAX_ADDR_C) ? MAX_ADDR_C : req_naddr;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_CMD1;
      end
      S_CMD1: begin
        idx_d = '0;
        twb_d = '0;
        if (naddr_q != '0) begin
          state_d = S_ADDR;
        end else if (has_cmd2_q) begin
          state_d = S_CMD2;
        end else begin
          state_d = S_GAP;
        end
      end
      S_ADDR: begin
        twb_d = '0;
        if (idx_q == naddr_q - NADDR_W'(1)) begin
          state_d = has_cmd2_q ? S_CMD2 : S_GAP;
        end else begin
          idx_d = idx_q + NADDR_W'(1);
        end
      end
      S_CMD2: begin
        twb_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (twb_q == TWB_LAST) begin
          state_d = S_BUSY;
`ifdef ONFI_RB_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          twb_d = twb_q + TWB_W'(1);
        end
      end
      S_BUSY: begin
        if (rb_s_q) begin
          state_d = S_DONE;
        end
`ifdef ONFI_RB_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          state_d     = S_DONE;
          timeout_hit = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pin values for the cycle the next state occupies
    cen_d   = (state_d == S_IDLE) || (state_d == S_DONE);
    cle_d   = (state_d == S_CMD1) || (state_d == S_CMD2);
    ale_d   = (state_d == S_ADDR);
    dq_en_d = cle_d || ale_d;
    dq_d    = '0;
    if (state_d == S_CMD1) begin
      dq_d = cmd1_d;
    end else if (state_d == S_CMD2) begin
      dq_d = cmd2_q;
    end else if (state_d == S_ADDR) begin
      dq_d = addr_byte;
    end
    done_d  = (state_d == S_DONE) && !timeout_hit;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
`ifdef ONFI_RB_TIMEOUT_EN
    err_d   = (state_d == S_DONE) && timeout_hit;
`endif
  end

  // State, captured request and output registers
  always_ff @(negedge onfi_clk) begin
    if (!onfi_rstn) begin
      state_q    <= S_IDLE;
      cmd1_q     <= '0;
      cmd2_q     <= '0;
      has_cmd2_q <= 1'b0;
      naddr_q    <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      twb_q      <= '0;
      cen_q      <= 1'b1;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      dq_en_q    <= 1'b0;
      dq_q       <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ONFI_RB_TIMEOUT_EN
      to_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd1_q     <= cmd1_d;
      cmd2_q     <= cmd2_d;
      has_cmd2_q <= has_cmd2_d;
      naddr_q    <= naddr_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      twb_q      <= twb_d;
      cen_q      <= cen_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      dq_en_q    <= dq_en_d;
      dq_q       <= dq_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef ONFI_RB_TIMEOUT_EN
      to_q       <= to_d;
      err_q      <= err_d;
`endif
    end
  end

  assign req_ready   = ready_q;
  assign op_done     = done_q;
  assign busy        = busy_q;
  assign onfi_cen    = cen_q;
  assign onfi_cle    = cle_q;
  assign onfi_ale    = ale_q;
  assign onfi_wen    = 1'b1;
  assign onfi_dqs_en = 1'b0;
  assign onfi_dq_o   = {(DQ_W - CMD_W)'(0), dq_q};
  assign onfi_dq_en  = dq_en_q;
`ifdef ONFI_RB_TIMEOUT_EN
  assign op_err      = err_q;
`else
  assign op_err      = 1'b0;
`endif

endmodule
